// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared widths, instruction fields and fetch states
package instruction_fetch_unit_pkg;

    localparam int INSTR_W = 29;
    localparam int ADDR_W  = 8;
    localparam int CNT_W   = 16;

    localparam int OPC_MSB  = 28;
    localparam int OPC_LSB  = 24;
    localparam int DST_MSB  = 23;
    localparam int DST_LSB  = 16;
    localparam int SRC1_MSB = 15;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_MSB = 7;
    localparam int SRC2_LSB = 0;

    localparam logic [4:0] HALT_OPCODE = 5'b11111;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - program memory, decode and redirect signals of the fetch stage
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic [ADDR_W-1:0]  out_pc_add;
    logic [INSTR_W-1:0] in_instruction;
    logic [INSTR_W-1:0] out_ir;
    logic [ADDR_W-1:0]  out_ir_pc;
    logic               out_ir_valid;
    logic               in_dec_ready;
    logic               in_branch_taken;
    logic [ADDR_W-1:0]  in_branch_target;
    logic               out_halted;
    logic [CNT_W-1:0]   out_fetch_count;

    modport master (
        output out_pc_add, out_ir, out_ir_pc, out_ir_valid, out_halted, out_fetch_count,
        input  in_instruction, in_dec_ready, in_branch_taken, in_branch_target
    );

    modport slave (
        input  out_pc_add, out_ir, out_ir_pc, out_ir_valid, out_halted, out_fetch_count,
        output in_instruction, in_dec_ready, in_branch_taken, in_branch_target
    );

endinterface

// File: rtl/instruction_fetch_unit_program_counter.sv
// rtl/instruction_fetch_unit_program_counter.sv - 8-bit PC, priority reset > redirect > increment
module instruction_fetch_unit_program_counter
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'd0
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              inc_en,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_target;
        end else if (inc_en) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC, IF/ID register, HALT state machine, transfer counter
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'd0
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    instruction_fetch_unit_if.master  bus
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [ADDR_W-1:0]  pc;
    logic               pc_inc;
    logic               pc_load;
    logic               transfer;

    instruction_fetch_unit_program_counter #(
        .RESET_PC (RESET_PC)
    ) u_program_counter (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .inc_en      (pc_inc),
        .load_en     (pc_load),
        .load_target (bus.in_branch_target),
        .pc          (pc)
    );

    assign transfer = ir_valid_q && bus.in_dec_ready;

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        count_d    = count_q;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;

        if (transfer && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end

        case (state_q)
            ST_RUN: begin
                // Redirect discards whatever memory returns this cycle, including a HALT word.
                if (bus.in_branch_taken) begin
                    pc_load    = 1'b1;
                    ir_valid_d = 1'b0;
                end else if (!ir_valid_q || bus.in_dec_ready) begin
                    ir_d       = bus.in_instruction;
                    ir_pc_d    = pc;
                    ir_valid_d = 1'b1;
                    pc_inc     = 1'b1;
                    if (is_halt(bus.in_instruction)) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (transfer) begin
                    ir_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q    <= ST_RUN;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    assign bus.out_pc_add      = pc;
    assign bus.out_ir          = ir_q;
    assign bus.out_ir_pc       = ir_pc_q;
    assign bus.out_ir_valid    = ir_valid_q;
    assign bus.out_halted      = halted_q;
    assign bus.out_fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [INSTR_W-1:0] mem [256];
    logic [INSTR_W-1:0] halt_word;

    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();
    instruction_fetch_unit_if bus2 ();

    instruction_fetch_unit u_dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus.master)
    );

    instruction_fetch_unit #(
        .RESET_PC (8'hFE)
    ) u_dut_fe (
        .in_clk (clk),
        .in_rst (rst2),
        .bus    (bus2.master)
    );

    assign bus.in_instruction  = mem[bus.out_pc_add];
    assign bus2.in_instruction = '0;
    assign bus2.in_dec_ready     = 1'b1;
    assign bus2.in_branch_taken  = 1'b0;
    assign bus2.in_branch_target = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_ir(input string tag, input logic [7:0] addr, input logic valid);
        check({tag, " ir_pc"}, 32'(bus.out_ir_pc), 32'(addr));
        check({tag, " ir"}, 32'(bus.out_ir), 32'(mem[addr]));
        check({tag, " ir_valid"}, 32'(bus.out_ir_valid), 32'(valid));
    endtask

    initial begin
        halt_word = {HALT_OPCODE, 24'h000005};
        for (int i = 0; i < 256; i++) begin
            mem[i] = {5'(i % 16), 8'(i), 8'(~i), 8'(i + 3)};
        end
        mem[0] = '0;
        mem[5] = halt_word;

        rst  = 1'b1;
        rst2 = 1'b1;
        bus.in_dec_ready     = 1'b1;
        bus.in_branch_taken  = 1'b0;
        bus.in_branch_target = 8'h00;
        tick();
        check("rst pc", 32'(bus.out_pc_add), 32'h00);
        check("rst ir", 32'(bus.out_ir), 32'h0);
        check("rst ir_pc", 32'(bus.out_ir_pc), 32'h0);
        check("rst ir_valid", 32'(bus.out_ir_valid), 32'h0);
        check("rst halted", 32'(bus.out_halted), 32'h0);
        check("rst count", 32'(bus.out_fetch_count), 32'h0);
        check("fe pc0", 32'(bus2.out_pc_add), 32'hFE);

        // Streaming with ready=1
        rst  = 1'b0;
        rst2 = 1'b0;
        tick();
        check("run pc1", 32'(bus.out_pc_add), 32'h01);
        check_ir("run a0", 8'h00, 1'b1);
        check("run count1", 32'(bus.out_fetch_count), 32'h0);
        check("fe pc1", 32'(bus2.out_pc_add), 32'hFF);
        tick();
        check("run pc2", 32'(bus.out_pc_add), 32'h02);
        check_ir("run a1", 8'h01, 1'b1);
        check("run count2", 32'(bus.out_fetch_count), 32'h1);
        check("fe pc2", 32'(bus2.out_pc_add), 32'h00);
        tick();
        check("run pc3", 32'(bus.out_pc_add), 32'h03);
        check_ir("run a2", 8'h02, 1'b1);
        check("run count3", 32'(bus.out_fetch_count), 32'h2);
        check("fe pc3", 32'(bus2.out_pc_add), 32'h01);

        // Decode back-pressure for four cycles
        bus.in_dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall pc", 32'(bus.out_pc_add), 32'h03);
            check_ir("stall", 8'h02, 1'b1);
            check("stall count", 32'(bus.out_fetch_count), 32'h2);
        end
        bus.in_dec_ready = 1'b1;
        tick();
        check_ir("release", 8'h03, 1'b1);
        check("release pc", 32'(bus.out_pc_add), 32'h04);
        check("release count", 32'(bus.out_fetch_count), 32'h3);

        // Redirect while stalled
        bus.in_dec_ready     = 1'b0;
        bus.in_branch_taken  = 1'b1;
        bus.in_branch_target = 8'h40;
        tick();
        check("br pc", 32'(bus.out_pc_add), 32'h40);
        check("br ir_valid", 32'(bus.out_ir_valid), 32'h0);
        check("br count", 32'(bus.out_fetch_count), 32'h3);
        bus.in_branch_taken = 1'b0;
        bus.in_dec_ready    = 1'b1;
        tick();
        check_ir("br target", 8'h40, 1'b1);
        check("br pc next", 32'(bus.out_pc_add), 32'h41);

        // Redirect with a same-cycle transfer still counts
        bus.in_branch_taken  = 1'b1;
        bus.in_branch_target = 8'h04;
        tick();
        check("br2 count", 32'(bus.out_fetch_count), 32'h4);
        check("br2 ir_valid", 32'(bus.out_ir_valid), 32'h0);
        check("br2 pc", 32'(bus.out_pc_add), 32'h04);
        bus.in_branch_taken = 1'b0;
        tick();
        check_ir("a4", 8'h04, 1'b1);
        check("a4 pc", 32'(bus.out_pc_add), 32'h05);

        // Redirect beats a HALT fetch
        bus.in_branch_taken  = 1'b1;
        bus.in_branch_target = 8'h05;
        tick();
        check("br halt halted", 32'(bus.out_halted), 32'h0);
        check("br halt ir_valid", 32'(bus.out_ir_valid), 32'h0);
        check("br halt pc", 32'(bus.out_pc_add), 32'h05);
        check("br halt count", 32'(bus.out_fetch_count), 32'h5);

        // HALT fetch
        bus.in_branch_taken = 1'b0;
        tick();
        check("halt halted", 32'(bus.out_halted), 32'h1);
        check_ir("halt", 8'h05, 1'b1);
        check("halt pc", 32'(bus.out_pc_add), 32'h06);

        bus.in_dec_ready     = 1'b0;
        bus.in_branch_taken  = 1'b1;
        bus.in_branch_target = 8'h20;
        tick();
        check("halt br pc", 32'(bus.out_pc_add), 32'h06);
        check_ir("halt hold", 8'h05, 1'b1);
        check("halt hold count", 32'(bus.out_fetch_count), 32'h5);

        bus.in_branch_taken = 1'b0;
        bus.in_dec_ready    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halted ir_valid", 32'(bus.out_ir_valid), 32'h0);
            check("halted pc", 32'(bus.out_pc_add), 32'h06);
            check("halted count", 32'(bus.out_fetch_count), 32'h6);
            check("halted flag", 32'(bus.out_halted), 32'h1);
        end

        // Reset mid-stall with count=7
        mem[5] = 29'h0123456;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        bus.in_dec_ready = 1'b0;
        tick();
        check("pre rst count", 32'(bus.out_fetch_count), 32'h7);
        check("pre rst pc", 32'(bus.out_pc_add), 32'h08);
        check_ir("pre rst", 8'h07, 1'b1);
        rst                  = 1'b1;
        bus.in_branch_taken  = 1'b1;
        bus.in_branch_target = 8'h33;
        bus.in_dec_ready     = 1'b1;
        tick();
        check("mid rst pc", 32'(bus.out_pc_add), 32'h00);
        check("mid rst ir", 32'(bus.out_ir), 32'h0);
        check("mid rst ir_pc", 32'(bus.out_ir_pc), 32'h0);
        check("mid rst ir_valid", 32'(bus.out_ir_valid), 32'h0);
        check("mid rst halted", 32'(bus.out_halted), 32'h0);
        check("mid rst count", 32'(bus.out_fetch_count), 32'h0);
        rst                 = 1'b0;
        bus.in_branch_taken = 1'b0;

        // Counter saturation on the free-running instance
        for (int i = 0; i < 65600; i++) tick();
        check("fe count sat", 32'(bus2.out_fetch_count), 32'hFFFF);
        check("fe halted", 32'(bus2.out_halted), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage for the 29-bit-instruction microprocessor. Owns the 8-bit program counter and drives the program memory address. Captures the combinational instruction word into an instruction register (IF/ID) and hands it to decode over a valid/ready handshake. Handles branch redirects, decode back-pressure and a HALT opcode.

## Interface
- RESET_PC, 8'd0, PC value loaded on reset
- HALT_OPCODE, 5'b11111, opcode (bits 28:24) that stops fetch
- in_clk  input  1  clock; all state updates on rising edge
- in_rst  input  1  reset; synchronous, active-high
- out_pc_add  output  8  address to program memory (registered PC, no combinational path)
- in_instruction  input  29  instruction word from program memory for out_pc_add, same cycle
- out_ir  output  29  instruction register contents
- out_ir_pc  output  8  address out_ir was fetched from
- out_ir_valid  output  1  out_ir holds a live instruction
- in_dec_ready  input  1  decode accepts out_ir this cycle
- in_branch_taken  input  1  redirect request from execute
- in_branch_target  input  8  redirect address
- out_halted  output  1  fetch stopped by HALT
- out_fetch_count  output  16  instructions accepted by decode, saturating

## Operation
- States: RUN, HALTED. Reset enters RUN.
- Reset values: pc=RESET_PC, out_ir=0, out_ir_pc=0, out_ir_valid=0, out_halted=0, out_fetch_count=0.
- Handshake: transfer occurs when out_ir_valid && in_dec_ready. out_ir, out_ir_pc and out_ir_valid are held stable while out_ir_valid && !in_dec_ready.
- Load condition in RUN: load = !out_ir_valid || in_dec_ready. On load: out_ir<=in_instruction, out_ir_pc<=pc, out_ir_valid<=1, pc<=pc+1.
- PC arithmetic is 8-bit modulo. 255 increments to 0, with no flag.
- Stall, meaning RUN with no load: pc unchanged and IR unchanged.
- Redirect (in_branch_taken=1 in RUN) has priority over load and stall:
  - pc<=in_branch_target and out_ir_valid<=0.
  - The current in_instruction is discarded.
  - A transfer that occurs in the same cycle still counts.
- HALT: if a load captures an instruction with bits[28:24]==HALT_OPCODE, the state goes to HALTED and out_halted<=1 on the same edge. pc does not advance past the HALT address (pc stays at HALT address+1 from the load).
- HALTED:
  - No loads.
  - The HALT instruction is still presented until transferred; then out_ir_valid<=0.
  - in_branch_taken is ignored.
  - Exit is by reset only.
- Redirect and HALT fetch in the same cycle: the redirect wins. The HALT word is not loaded and the state stays RUN.
- out_fetch_count increments on each transfer and saturates at 16'hFFFF.
- Reset mid-operation: all state returns to reset values on that edge, regardless of other inputs.

## Timing
- Address to IR latency: out_pc_add=A in cycle n gives out_ir=p_mem[A] and out_ir_valid=1 in cycle n+1.
- Steady state with in_dec_ready=1: one instruction per cycle. First valid IR appears in the 2nd cycle after reset deasserts.
- Redirect asserted in cycle n:
  - Cycle n+1: out_pc_add=target, out_ir_valid=0.
  - Cycle n+2: out_ir holds the target instruction.
  - Branch penalty is one bubble.
- out_halted rises in the same cycle that the HALT word appears in out_ir.
- All outputs are registered or derived from registers only. in_dec_ready does not combinationally affect any output.

## Structure
- Shared package holds:
  - Instruction field constants: OPC[28:24], DST[23:16], SRC1[15:8], SRC2/IMM[7:0].
  - INSTR_W=29, ADDR_W=8, and the HALT opcode value.
  - State encoding for RUN/HALTED.
- One sub-module is natural: program_counter. It contains the 8-bit register with reset, increment-enable and load-target inputs, and handles next-PC priority (reset > redirect > increment).
- The top-level block holds the IR, the state machine and the counter.

## Test plan
- Program 0:NOP, 1..3 arbitrary, in_dec_ready=1 after reset:
  - out_pc_add goes 0,1,2,3 on consecutive cycles.
  - out_ir_pc lags by one cycle.
  - out_fetch_count=3 after three transfers.
- in_dec_ready=0 for 4 cycles with IR valid at addr 2:
  - out_ir and out_ir_pc=2 stay stable and pc stays 3.
  - After release, the next IR is addr 3.
- in_branch_taken=1, target=8'h40, asserted while stalled:
  - Next cycle: out_ir_valid=0 and out_pc_add=8'h40.
  - Cycle after: out_ir_pc=8'h40.
- HALT at addr 5:
  - out_halted=1 with out_ir_pc=5.
  - Redirect is ignored.
  - After the transfer, out_ir_valid=0 permanently until in_rst.
- RESET_PC=8'hFE, ready=1:
  - pc sequence is FE, FF, 00, 01.
- in_rst asserted mid-stall with count=7:
  - Next cycle: all outputs are at reset values and out_pc_add=RESET_PC.
